// File: rtl/pcnt_frame_sched_pkg.sv
// Shared types and defaults for the frame popcount scheduler and its beat pipeline.
package pcnt_frame_sched_pkg;

    localparam int DEF_BEAT_W    = 32;
    localparam int DEF_CNT_W     = 16;
    localparam int DEF_FLUSH_CYC = 2;

    // Fixed latency of the beat popcount pipeline, in clock edges.
    localparam int PIPE_LAT = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_FLUSH = 2'd2,
        ST_OUT   = 2'd3
    } state_e;

    // Width needed to hold a popcount of 0..beat_w.
    function automatic int pcnt_w(input int beat_w);
        return $clog2(beat_w + 1);
    endfunction

endpackage

// File: rtl/pcnt_beat_pipe.sv
// Two-stage registered popcount of one beat.
// Stage 1 reduces every byte to its 4-bit count in a compressor slice.
// Stage 2 sums the slice counts into the beat count.
// A cycle with in_vld low pushes a zero beat, so the pipe drains to zero counts.
module pcnt_beat_pipe
    import pcnt_frame_sched_pkg::*;
#(
    parameter int BEAT_W = DEF_BEAT_W,
    parameter int PCNT_W = pcnt_w(DEF_BEAT_W)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              in_vld,
    input  logic [BEAT_W-1:0] in_data,
    output logic [PCNT_W-1:0] cnt_o
);

    localparam int N_SLICE = BEAT_W / 8;

    logic [3:0]        slice_d [N_SLICE];
    logic [3:0]        slice_q [N_SLICE];
    logic [PCNT_W-1:0] sum_d;
    logic [PCNT_W-1:0] sum_q;

    function automatic logic [3:0] byte_ones(input logic [7:0] b);
        logic [3:0] s;
        s = '0;
        for (int i = 0; i < 8; i++) begin
            s = s + {3'b000, b[i]};
        end
        return s;
    endfunction

    // Stage 1 input: per-byte counts; an idle cycle contributes zero.
    always_comb begin
        for (int i = 0; i < N_SLICE; i++) begin
            slice_d[i] = in_vld ? byte_ones(in_data[8*i +: 8]) : 4'd0;
        end
    end

    // Stage 2 input: sum of the registered slice counts.
    always_comb begin
        sum_d = '0;
        for (int i = 0; i < N_SLICE; i++) begin
            sum_d = sum_d + PCNT_W'(slice_q[i]);
        end
    end

    // Pipeline registers; clr empties both stages.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_SLICE; i++) begin
                slice_q[i] <= '0;
            end
            sum_q <= '0;
        end else if (clr) begin
            for (int i = 0; i < N_SLICE; i++) begin
                slice_q[i] <= '0;
            end
            sum_q <= '0;
        end else begin
            for (int i = 0; i < N_SLICE; i++) begin
                slice_q[i] <= slice_d[i];
            end
            sum_q <= sum_d;
        end
    end

    assign cnt_o = sum_q;

endmodule

// File: rtl/pcnt_frame_sched.sv
// Frame scheduler: accepts beats, accumulates their popcounts and beat count,
// drains the beat pipeline after the last beat and presents one saturated result.
//
// Handshakes: a beat transfers on a rising edge where in_valid & in_ready;
// a result transfers on a rising edge where out_valid & out_ready. Data and
// in_last are ignored without a transfer; out_* hold stable while out_valid
// waits for out_ready.
//
// FLUSH_CYC must be at least the pipeline latency (2) so the last beat's count
// has reached the accumulator before the result is latched.
module pcnt_frame_sched
    import pcnt_frame_sched_pkg::*;
#(
    parameter int BEAT_W    = DEF_BEAT_W,
    parameter int CNT_W     = DEF_CNT_W,
    parameter int FLUSH_CYC = DEF_FLUSH_CYC
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [BEAT_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  out_count,
    output logic [CNT_W-1:0]  out_beats,
    output logic              out_sat,
    output logic              busy
);

    localparam int          PCNT_W  = pcnt_w(BEAT_W);
    localparam int          FC_W    = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
    localparam logic [CNT_W:0] CNT_MAX = {1'b0, {CNT_W{1'b1}}};

    state_e            state_q,     state_d;
    logic [FC_W-1:0]   fcnt_q,      fcnt_d;
    logic [CNT_W:0]    acc_q,       acc_d;
    logic [CNT_W:0]    beats_q,     beats_d;
    logic              sat_q,       sat_d;
    logic              in_ready_q,  in_ready_d;
    logic              out_valid_q, out_valid_d;
    logic [CNT_W-1:0]  out_count_q, out_count_d;
    logic [CNT_W-1:0]  out_beats_q, out_beats_d;
    logic              out_sat_q,   out_sat_d;
    logic              busy_q,      busy_d;

    logic              xfer;
    logic [PCNT_W-1:0] pipe_cnt;
    logic [CNT_W:0]    acc_sum;
    logic [CNT_W:0]    beats_inc;

    assign xfer = in_valid & in_ready_q;

    pcnt_beat_pipe #(
        .BEAT_W (BEAT_W),
        .PCNT_W (PCNT_W)
    ) u_pipe (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (clr),
        .in_vld  (xfer & ~clr),
        .in_data (in_data),
        .cnt_o   (pipe_cnt)
    );

    // Next-state, accumulation and registered-output logic.
    always_comb begin
        state_d     = state_q;
        fcnt_d      = fcnt_q;
        acc_d       = acc_q;
        beats_d     = beats_q;
        sat_d       = sat_q;
        out_valid_d = out_valid_q;
        out_count_d = out_count_q;
        out_beats_d = out_beats_q;
        out_sat_d   = out_sat_q;

        // The pipe emits zero when no beat is in flight, so adding every cycle is safe.
        acc_sum = acc_q + (CNT_W+1)'(pipe_cnt);
        if (acc_sum > CNT_MAX) begin
            acc_d = CNT_MAX;
            sat_d = 1'b1;
        end else begin
            acc_d = acc_sum;
        end

        beats_inc = beats_q + (CNT_W+1)'(1);
        if (xfer) begin
            if (beats_inc > CNT_MAX) begin
                beats_d = CNT_MAX;
                sat_d   = 1'b1;
            end else begin
                beats_d = beats_inc;
            end
        end

        case (state_q)
            ST_IDLE, ST_ACCUM: begin
                if (xfer) begin
                    if (in_last) begin
                        state_d = ST_FLUSH;
                        fcnt_d  = FC_W'(FLUSH_CYC - 1);
                    end else begin
                        state_d = ST_ACCUM;
                    end
                end
            end
            ST_FLUSH: begin
                if (fcnt_q == '0) begin
                    state_d = ST_OUT;
                end else begin
                    fcnt_d = fcnt_q - FC_W'(1);
                end
            end
            ST_OUT: begin
                if (!out_valid_q) begin
                    out_valid_d = 1'b1;
                    out_count_d = acc_q[CNT_W-1:0];
                    out_beats_d = beats_q[CNT_W-1:0];
                    out_sat_d   = sat_q;
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                    acc_d       = '0;
                    beats_d     = '0;
                    sat_d       = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Abort wins over any beat or result transfer in the same cycle.
        if (clr) begin
            state_d     = ST_IDLE;
            fcnt_d      = '0;
            acc_d       = '0;
            beats_d     = '0;
            sat_d       = 1'b0;
            out_valid_d = 1'b0;
        end

        in_ready_d = (state_d == ST_IDLE) || (state_d == ST_ACCUM);
        busy_d     = (state_d != ST_IDLE);
    end

    // FSM and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            fcnt_q      <= '0;
            acc_q       <= '0;
            beats_q     <= '0;
            sat_q       <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_count_q <= '0;
            out_beats_q <= '0;
            out_sat_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            fcnt_q      <= fcnt_d;
            acc_q       <= acc_d;
            beats_q     <= beats_d;
            sat_q       <= sat_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_count_q <= out_count_d;
            out_beats_q <= out_beats_d;
            out_sat_q   <= out_sat_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_count = out_count_q;
    assign out_beats = out_beats_q;
    assign out_sat   = out_sat_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_pcnt_frame_sched.sv
// Bench for pcnt_frame_sched: two instances (CNT_W=16 and CNT_W=8) share one
// stimulus stream; a frame-level model predicts each saturated result.
module tb_pcnt_frame_sched;

  localparam int FLUSH_CYC = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_last = 1'b0;
  logic        out_ready = 1'b0;

  logic        in_ready_a, out_valid_a, out_sat_a, busy_a;
  logic [15:0] out_count_a, out_beats_a;
  logic        in_ready_b, out_valid_b, out_sat_b, busy_b;
  logic [7:0]  out_count_b, out_beats_b;

  int n_assert = 0;
  int n_fail = 0;

  // Frame model: running totals of the open frame, queue of closed frames.
  int m_ones = 0;
  int m_beats = 0;
  logic [31:0] exp_ones_q[$];
  logic [31:0] exp_beats_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  pcnt_frame_sched #(.BEAT_W(32), .CNT_W(16), .FLUSH_CYC(FLUSH_CYC)) dut_a (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready_a), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid_a), .out_ready(out_ready),
    .out_count(out_count_a), .out_beats(out_beats_a), .out_sat(out_sat_a), .busy(busy_a)
  );

  pcnt_frame_sched #(.BEAT_W(32), .CNT_W(8), .FLUSH_CYC(FLUSH_CYC)) dut_b (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready_b), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid_b), .out_ready(out_ready),
    .out_count(out_count_b), .out_beats(out_beats_b), .out_sat(out_sat_b), .busy(busy_b)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: observed no end of test, expected end before 500000");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] clamp(input logic [31:0] v, input logic [31:0] mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic chk_idle_ctrl(input string tag, input logic exp_ready, input logic exp_busy);
    chk({tag, "_valid_a"}, out_valid_a, 1'b0);
    chk({tag, "_valid_b"}, out_valid_b, 1'b0);
    chk({tag, "_ready_a"}, in_ready_a, exp_ready);
    chk({tag, "_ready_b"}, in_ready_b, exp_ready);
    chk({tag, "_busy_a"}, busy_a, exp_busy);
    chk({tag, "_busy_b"}, busy_b, exp_busy);
  endtask

  task automatic chk_result(input string tag, input logic [31:0] ones, input logic [31:0] beats);
    chk({tag, "_valid_a"}, out_valid_a, 1'b1);
    chk({tag, "_valid_b"}, out_valid_b, 1'b1);
    chk({tag, "_ready_a"}, in_ready_a, 1'b0);
    chk({tag, "_count_a"}, out_count_a, clamp(ones, 32'd65535));
    chk({tag, "_beats_a"}, out_beats_a, clamp(beats, 32'd65535));
    chk({tag, "_sat_a"}, out_sat_a, (ones > 65535) || (beats > 65535));
    chk({tag, "_count_b"}, out_count_b, clamp(ones, 32'd255));
    chk({tag, "_beats_b"}, out_beats_b, clamp(beats, 32'd255));
    chk({tag, "_sat_b"}, out_sat_b, (ones > 255) || (beats > 255));
  endtask

  // ---------------- driver tasks ----------------
  // Offers one beat and returns #1 after the edge that took it.
  task automatic send_beat(input logic [31:0] d, input logic l);
    int g;
    g = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    while (in_ready_a !== 1'b1 && g < 100) begin
      @(posedge clk); #1;
      g++;
    end
    chk("beat_wait_cycles_ok", (g < 100), 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    m_ones  += $countones(d);
    m_beats += 1;
    if (l) begin
      exp_ones_q.push_back(m_ones);
      exp_beats_q.push_back(m_beats);
      m_ones  = 0;
      m_beats = 0;
    end
  endtask

  // Called right after the last beat was taken; checks latency, hold, handshake.
  task automatic expect_result(input string tag, input int stall);
    logic [31:0] ones, beats;
    ones  = exp_ones_q.pop_front();
    beats = exp_beats_q.pop_front();
    out_ready = (stall == 0);
    for (int k = 1; k <= FLUSH_CYC; k++) begin
      @(posedge clk); #1;
      chk_idle_ctrl({tag, "_drain"}, 1'b0, 1'b1);
    end
    @(posedge clk); #1;
    chk_result(tag, ones, beats);
    for (int k = 0; k < stall; k++) begin
      @(posedge clk); #1;
      chk_result({tag, "_hold"}, ones, beats);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk_idle_ctrl({tag, "_taken"}, 1'b1, 1'b0);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int len;
    int stall;
    logic [31:0] d;

    // Reset state
    #3;
    chk_idle_ctrl("reset", 1'b0, 1'b0);
    chk("reset_count_a", out_count_a, 32'd0);
    chk("reset_beats_a", out_beats_a, 32'd0);
    chk("reset_sat_a", out_sat_a, 1'b0);
    @(posedge clk); #1;
    chk("reset_hold_ready", in_ready_a, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("release_ready_before_edge", in_ready_a, 1'b0);
    @(posedge clk); #1;
    chk_idle_ctrl("release", 1'b1, 1'b0);

    // 1: single full beat
    send_beat(32'hFFFF_FFFF, 1'b1);
    expect_result("t1", 0);

    // 2: four beats back to back (22 ones)
    send_beat(32'h0000_000F, 1'b0);
    send_beat(32'h8000_0001, 1'b0);
    send_beat(32'h0000_0000, 1'b0);
    send_beat(32'hAAAA_AAAA, 1'b1);
    expect_result("t2", 0);

    // all-zero frame is a valid zero result
    send_beat(32'h0000_0000, 1'b1);
    expect_result("zero", 0);

    // 3: back-pressure with the next beat already offered
    send_beat(32'h0000_001F, 1'b1);
    in_valid = 1'b1;
    in_data  = 32'h0000_0001;
    in_last  = 1'b1;
    expect_result("t3", 10);
    send_beat(32'h0000_0001, 1'b1);
    expect_result("t3_next", 0);

    // 4: saturation on the narrow instance, then a clean frame
    for (int i = 0; i < 9; i++) send_beat(32'hFFFF_FFFF, (i == 8));
    expect_result("t4", 0);
    send_beat(32'h0000_0001, 1'b1);
    expect_result("t4_next", 0);

    // 5: clr coincident with a third beat
    send_beat(32'hFFFF_FFFF, 1'b0);
    send_beat(32'hFFFF_FFFF, 1'b0);
    in_valid = 1'b1;
    in_data  = 32'hFFFF_FFFF;
    in_last  = 1'b0;
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    in_valid = 1'b0;
    m_ones  = 0;
    m_beats = 0;
    chk_idle_ctrl("t5_clr", 1'b1, 1'b0);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk("t5_no_valid", out_valid_a | out_valid_b, 1'b0);
    end
    send_beat(32'h0000_0003, 1'b1);
    expect_result("t5", 0);

    // 6: reset pulse during FLUSH
    send_beat(32'h0000_00FF, 1'b1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk_idle_ctrl("t6_async", 1'b0, 1'b0);
    exp_ones_q.delete();
    exp_beats_q.delete();
    @(posedge clk); #1;
    chk("t6_ready_in_reset", in_ready_a, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk_idle_ctrl("t6_release", 1'b1, 1'b0);
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      chk("t6_no_stale", out_valid_a | out_valid_b, 1'b0);
    end

    // Random frames
    for (int f = 0; f < 25; f++) begin
      len   = $urandom_range(1, 6);
      stall = $urandom_range(0, 3);
      for (int i = 0; i < len; i++) begin
        case ($urandom_range(0, 3))
          0: d = 32'h0000_0000;
          1: d = 32'hFFFF_FFFF;
          default: d = $urandom;
        endcase
        send_beat(d, (i == len - 1));
      end
      expect_result("rand", stall);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
